// File: rtl/sparse_mxv_pkg.sv
// Shared types and helpers for the sparse matrix-vector datapath.
// Build option: SPARSE_PSUM_RELU_EN (consumed by sparse_psum_accum).
package sparse_mxv_pkg;

    localparam int PSUM_W    = 16;
    localparam int ROW_IDX_W = 12;
    localparam int TILE_X    = 32;

    typedef logic signed [PSUM_W-1:0] psum_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2
    } acc_state_e;

    localparam int PSUM_MAX = (1 << (PSUM_W - 1)) - 1;
    localparam int PSUM_MIN = -(1 << (PSUM_W - 1));

    // Clamp a sign-extended accumulator into the partial-sum range; never wraps.
    function automatic psum_t sat_psum(input logic signed [31:0] a);
        if (a > 32'(PSUM_MAX))
            return psum_t'(PSUM_MAX);
        else if (a < 32'(PSUM_MIN))
            return psum_t'(PSUM_MIN);
        else
            return psum_t'(a);
    endfunction

endpackage

// File: rtl/psum_result_fifo.sv
// Small synchronous first-word-fall-through FIFO holding tagged row results.
// A read in the same cycle as a write to a full FIFO frees the slot for the write.
module psum_result_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             rd_fire;
    logic             wr_fire;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);

    // Head entry is presented directly; zero while empty so idle outputs stay quiet.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because empty masks the output.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sparse_psum_accum.sv
// Accumulates TILES_PER_ROW partial sums per row, saturates to 16 bits, tags with
// the row index and buffers in a result FIFO drained over valid/ready.
// Build option: SPARSE_PSUM_RELU_EN clamps negative row results to zero.
// Saturation uses the 16-bit psum_t from sparse_mxv_pkg; ACC_W must be <= 32.
module sparse_psum_accum #(
    parameter int PSUM_W        = 16,
    parameter int ACC_W         = 24,
    parameter int TILES_PER_ROW = 12,
    parameter int NUM_ROWS      = 128,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic              psum_valid,
    output logic              psum_ready,
    output logic [PSUM_W-1:0] res_data,
    output logic [11:0]       res_row,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              pass_done
);
    import sparse_mxv_pkg::*;

    localparam logic [7:0]           LAST_TILE = 8'(TILES_PER_ROW - 1);
    localparam logic [ROW_IDX_W-1:0] LAST_ROW  = ROW_IDX_W'(NUM_ROWS - 1);
    localparam int                   ENTRY_W   = ROW_IDX_W + PSUM_W;

    acc_state_e               state;
    logic signed [ACC_W-1:0]  acc;
    logic [7:0]               tile_cnt;
    logic [ROW_IDX_W-1:0]     row_cnt;
    psum_t                    sat_val;
    psum_t                    wr_val;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_wr;
    logic [ENTRY_W-1:0]       fifo_head;

    assign psum_ready = (state == ACC);

    // Saturated (and optionally rectified) row value presented to the FIFO during FLUSH.
    always_comb begin
        sat_val = sat_psum(32'(acc));
        wr_val  = sat_val;
`ifdef SPARSE_PSUM_RELU_EN
        if (sat_val < 0) wr_val = '0;
`else
        wr_val  = sat_val;
`endif
    end

    // A FLUSH write may proceed into a full FIFO when the consumer frees the head this cycle.
    assign fifo_wr = (state == FLUSH) && (!fifo_full || res_ready);

    // Row accumulation FSM: IDLE waits for start, ACC sums tiles, FLUSH commits the row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            tile_cnt  <= '0;
            row_cnt   <= '0;
            pass_done <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACC;
                        acc      <= '0;
                        tile_cnt <= '0;
                        row_cnt  <= '0;
                    end
                end
                ACC: begin
                    if (psum_valid) begin
                        acc <= acc + {{(ACC_W-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
                        if (tile_cnt == LAST_TILE) begin
                            tile_cnt <= '0;
                            state    <= FLUSH;
                        end else begin
                            tile_cnt <= tile_cnt + 8'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (fifo_wr) begin
                        acc <= '0;
                        if (row_cnt == LAST_ROW) begin
                            pass_done <= 1'b1;
                            row_cnt   <= '0;
                            state     <= IDLE;
                        end else begin
                            row_cnt <= row_cnt + ROW_IDX_W'(1);
                            state   <= ACC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    psum_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data ({row_cnt, wr_val}),
        .rd_en   (res_ready),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign res_valid = !fifo_empty;
    assign res_row   = fifo_head[ENTRY_W-1:PSUM_W];
    assign res_data  = fifo_head[PSUM_W-1:0];

endmodule

// File: tb/tb_sparse_psum_accum.sv
// Scoreboard bench for sparse_psum_accum: 4 tiles/row, 6 rows/pass, 4-deep FIFO.
// Honours SPARSE_PSUM_RELU_EN in its reference model.
module tb_sparse_psum_accum;

    localparam int TILES = 4;
    localparam int ROWS  = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] psum_in = '0;
    logic        psum_valid = 1'b0;
    logic        psum_ready;
    logic [15:0] res_data;
    logic [11:0] res_row;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic        pass_done;

    typedef struct {
        int row;
        int data;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   pass_cnt = 0;
    int   exp_row = 0;

    sparse_psum_accum #(
        .PSUM_W        (16),
        .ACC_W         (24),
        .TILES_PER_ROW (TILES),
        .NUM_ROWS      (ROWS),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .res_data   (res_data),
        .res_row    (res_row),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .pass_done  (pass_done)
    );

    always #5 clk = ~clk;

    function automatic int model_row(input int s);
        int r;
        r = s;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`ifdef SPARSE_PSUM_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int v);
        int n;
        n = 0;
        psum_in    = 16'(v);
        psum_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (psum_ready) break;
            n++;
            if (n > 400) begin
                tests++; fails++;
                $display("FAIL send_timeout: psum_ready=%0b required 1", psum_ready);
                break;
            end
        end
        @(posedge clk); #1;
        psum_valid = 1'b0;
    endtask

    // Sends one row; gaps inserts random idle cycles, start_mid pulses start after tile 1.
    task automatic send_row(input int v [4], input bit gaps, input bit start_mid);
        int sum;
        sum = 0;
        for (int i = 0; i < TILES; i++) begin
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 3));
                repeat (g) begin @(posedge clk); #1; end
            end
            send(v[i]);
            sum += v[i];
            if (start_mid && i == 1) pulse_start();
        end
        q.push_back('{row: exp_row, data: model_row(sum)});
        exp_row = (exp_row + 1) % ROWS;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || res_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests += 5;
        if (psum_ready !== 1'b0) begin fails++; $display("FAIL reset_psum_ready: got %0b want 0", psum_ready); end
        if (res_valid !== 1'b0)  begin fails++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
        if (res_data !== 16'd0)  begin fails++; $display("FAIL reset_res_data: got %0d want 0", res_data); end
        if (res_row !== 12'd0)   begin fails++; $display("FAIL reset_res_row: got %0d want 0", res_row); end
        if (pass_done !== 1'b0)  begin fails++; $display("FAIL reset_pass_done: got %0b want 0", pass_done); end
        @(posedge clk); #1;
    endtask

    task automatic run_basic_pass(input bit start_mid, input string tag);
        pass_cnt = 0;
        exp_row  = 0;
        pulse_start();
        send_row('{100, 200, -50, 25}, 1'b0, start_mid);
        send_row('{1, 2, 3, 4}, 1'b0, 1'b0);
        send_row('{-7, 8, -9, 10}, 1'b0, 1'b0);
        send_row('{0, 0, 0, 0}, 1'b0, 1'b0);
        send_row('{-1000, -2000, 500, 1}, 1'b0, 1'b0);
        send_row('{1234, 4321, -1, 6}, 1'b0, 1'b0);
        drain();
        tests += 2;
        if (pass_cnt !== 1) begin fails++; $display("FAIL %s_pass_done: pulses %0d want 1", tag, pass_cnt); end
        if (psum_ready !== 1'b0) begin fails++; $display("FAIL %s_idle: psum_ready %0b want 0", tag, psum_ready); end
    endtask

    task automatic test_basic();
        run_basic_pass(1'b0, "basic");
    endtask

    task automatic test_start_ignored();
        run_basic_pass(1'b1, "start_ignored");
    endtask

    task automatic test_saturation();
        exp_row = 0;
        pulse_start();
        send_row('{30000, 30000, 30000, 30000}, 1'b0, 1'b0);
        send_row('{-30000, -30000, -30000, -30000}, 1'b0, 1'b0);
        send_row('{32767, 0, 0, 0}, 1'b0, 1'b0);
        send_row('{-32768, 0, 0, 0}, 1'b0, 1'b0);
        send_row('{32767, 1, 0, 0}, 1'b0, 1'b0);
        send_row('{-32768, -1, 0, 0}, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_fifo_full();
        exp_row   = 0;
        res_ready = 1'b0;
        pulse_start();
        for (int r = 0; r < 5; r++)
            send_row('{r * 10 + 1, r * 10 + 2, -3, 4}, 1'b0, 1'b0);
        // FIFO holds rows 0..3; row 4 is parked in FLUSH.
        repeat (5) begin
            @(negedge clk);
            tests += 3;
            if (psum_ready !== 1'b0) begin fails++; $display("FAIL full_stall: psum_ready %0b want 0", psum_ready); end
            if (res_data !== 16'(q[0].data)) begin fails++; $display("FAIL full_hold_data: got %0d want %0d", $signed(res_data), q[0].data); end
            if (res_row !== 12'd0) begin fails++; $display("FAIL full_hold_row: got %0d want 0", res_row); end
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        send_row('{5, 6, 7, 8}, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_random_valid();
        exp_row = 0;
        pulse_start();
        for (int r = 0; r < ROWS; r++) begin
            int v [4];
            for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 65535)) - 32768;
            send_row(v, 1'b1, 1'b0);
        end
        drain();
    endtask

    task automatic test_reset_mid_row();
        exp_row   = 0;
        res_ready = 1'b0;
        pulse_start();
        send_row('{9, 9, 9, 9}, 1'b0, 1'b0);
        send(11);
        send(12);
        repeat (2) begin @(posedge clk); #1; end
        tests++;
        if (res_valid !== 1'b1) begin fails++; $display("FAIL midrst_prefill: res_valid %0b want 1", res_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        tests += 4;
        if (psum_ready !== 1'b0) begin fails++; $display("FAIL midrst_psum_ready: got %0b want 0", psum_ready); end
        if (res_valid !== 1'b0)  begin fails++; $display("FAIL midrst_res_valid: got %0b want 0", res_valid); end
        if (res_data !== 16'd0)  begin fails++; $display("FAIL midrst_res_data: got %0d want 0", res_data); end
        if (pass_done !== 1'b0)  begin fails++; $display("FAIL midrst_pass_done: got %0b want 0", pass_done); end
        @(posedge clk); #1;
        res_ready = 1'b1;
        run_basic_pass(1'b0, "after_reset");
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (pass_done) pass_cnt++;
                if (res_valid && res_ready) begin
                    if (q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_result: row %0d data %0d, none expected", res_row, $signed(res_data));
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        tests += 2;
                        if (res_data !== 16'(e.data)) begin
                            fails++;
                            $display("FAIL res_data row %0d: got %0d want %0d", e.row, $signed(res_data), e.data);
                        end
                        if (res_row !== 12'(e.row)) begin
                            fails++;
                            $display("FAIL res_row: got %0d want %0d", res_row, e.row);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_basic();
        test_saturation();
        test_fifo_full();
        test_random_valid();
        test_reset_mid_row();
        test_start_ignored();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
